// File: rtl/axi_grid_sub_ni.sv
// Grid-side subordinate network interface: terminates grid AW/W/AR flits for NI_ID,
// drives a local AXI manager port and routes B/R responses back to the requester.

package axi_default_param_pkg;
  typedef logic [3:0] grid_id_t;
  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} grid_aw_chan_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} grid_w_chan_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} grid_b_chan_t;
  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} grid_ar_chan_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} grid_r_chan_t;
endpackage

// Two-entry skid buffer; ready is a function of occupancy only and the output is registered.
module axi_grid_sub_ni_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] spare_r;
  logic [1:0]       count_r;
  logic             push_s;
  logic             pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = head_r;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Occupancy update: head always holds the oldest beat.
  always_ff @(posedge clk) begin
    if (srst) begin
      head_r  <= '0;
      spare_r <= '0;
      count_r <= 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_r  <= in_data;
            count_r <= 2'd1;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_r <= in_data;
          end else if (push_s) begin
            spare_r <= in_data;
            count_r <= 2'd2;
          end else if (pop_s) begin
            count_r <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_r  <= spare_r;
            count_r <= 2'd1;
          end
        end
        default: count_r <= 2'd0;
      endcase
    end
  end
endmodule

// Source-ID FIFO remembering who issued each outstanding request.
module axi_grid_sub_ni_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == '0);

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push && !pop) begin
        count_r <= count_r + CNT_ONE;
      end else if (!push && pop) begin
        count_r <= count_r - CNT_ONE;
      end
    end
  end
endmodule

module axi_grid_sub_ni #(
  parameter type grid_id_t      = axi_default_param_pkg::grid_id_t,
  parameter type grid_aw_chan_t = axi_default_param_pkg::grid_aw_chan_t,
  parameter type grid_w_chan_t  = axi_default_param_pkg::grid_w_chan_t,
  parameter type grid_b_chan_t  = axi_default_param_pkg::grid_b_chan_t,
  parameter type grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
  parameter type grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
  parameter grid_id_t NI_ID     = '0,
  parameter int MAX_WR          = 4,
  parameter int MAX_RD          = 4
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  grid_id_t      g_awdid_i,
  input  grid_id_t      g_awsid_i,
  input  grid_aw_chan_t g_awchan_i,
  input  logic          g_awvalid_i,
  output logic          g_awready_o,
  input  grid_id_t      g_wdid_i,
  input  grid_id_t      g_wsid_i,
  input  grid_w_chan_t  g_wchan_i,
  input  logic          g_wvalid_i,
  output logic          g_wready_o,
  input  grid_id_t      g_ardid_i,
  input  grid_id_t      g_arsid_i,
  input  grid_ar_chan_t g_archan_i,
  input  logic          g_arvalid_i,
  output logic          g_arready_o,
  output grid_id_t      g_bdid_o,
  output grid_id_t      g_bsid_o,
  output grid_b_chan_t  g_bchan_o,
  output logic          g_bvalid_o,
  input  logic          g_bready_i,
  output grid_id_t      g_rdid_o,
  output grid_id_t      g_rsid_o,
  output grid_r_chan_t  g_rchan_o,
  output logic          g_rvalid_o,
  input  logic          g_rready_i,
  output grid_aw_chan_t m_awchan_o,
  output logic          m_awvalid_o,
  input  logic          m_awready_i,
  output grid_w_chan_t  m_wchan_o,
  output logic          m_wvalid_o,
  input  logic          m_wready_i,
  output grid_ar_chan_t m_archan_o,
  output logic          m_arvalid_o,
  input  logic          m_arready_i,
  input  grid_b_chan_t  m_bchan_i,
  input  logic          m_bvalid_i,
  output logic          m_bready_o,
  input  grid_r_chan_t  m_rchan_i,
  input  logic          m_rvalid_i,
  output logic          m_rready_o,
  output logic          misroute_o
);
  localparam int IDW = $bits(grid_id_t);
  localparam int BW  = 2 * IDW + $bits(grid_b_chan_t);
  localparam int RW  = 2 * IDW + $bits(grid_r_chan_t);
  localparam int CW  = $clog2(MAX_WR) + 1;
  localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

  logic          aw_mis_s, w_mis_s, ar_mis_s;
  logic          aw_skid_ready_s, w_skid_ready_s, ar_skid_ready_s;
  logic          b_skid_ready_s, r_skid_ready_s;
  logic          aw_acc_s, w_fwd_s, w_last_s, ar_acc_s;
  logic          wr_full_s, wr_empty_s, rd_full_s, rd_empty_s;
  logic          b_acc_s, r_acc_s;
  grid_id_t      wr_head_s, rd_head_s;
  logic [BW-1:0] b_in_s, b_out_s;
  logic [RW-1:0] r_in_s, r_out_s;
  logic [CW-1:0] credit_r;
  logic          misroute_r;
  logic          unused_wsid_s;

  // Write data is matched to its AW by order, so the W source ID carries no information.
  assign unused_wsid_s = ^g_wsid_i;

  assign aw_mis_s = (g_awdid_i != NI_ID);
  assign w_mis_s  = (g_wdid_i != NI_ID);
  assign ar_mis_s = (g_ardid_i != NI_ID);

  assign g_awready_o = aw_mis_s | (aw_skid_ready_s & ~wr_full_s);
  assign g_wready_o  = w_mis_s | ((credit_r != '0) & w_skid_ready_s);
  assign g_arready_o = ar_mis_s | (ar_skid_ready_s & ~rd_full_s);

  assign aw_acc_s = g_awvalid_i & ~aw_mis_s & aw_skid_ready_s & ~wr_full_s;
  assign w_fwd_s  = g_wvalid_i & ~w_mis_s & (credit_r != '0) & w_skid_ready_s;
  assign w_last_s = w_fwd_s & g_wchan_i.last;
  assign ar_acc_s = g_arvalid_i & ~ar_mis_s & ar_skid_ready_s & ~rd_full_s;

  assign m_bready_o = ~wr_empty_s & b_skid_ready_s;
  assign m_rready_o = ~rd_empty_s & r_skid_ready_s;
  assign b_acc_s    = m_bvalid_i & m_bready_o;
  assign r_acc_s    = m_rvalid_i & m_rready_o;

  assign b_in_s = {wr_head_s, NI_ID, m_bchan_i};
  assign r_in_s = {rd_head_s, NI_ID, m_rchan_i};
  assign {g_bdid_o, g_bsid_o, g_bchan_o} = b_out_s;
  assign {g_rdid_o, g_rsid_o, g_rchan_o} = r_out_s;
  assign misroute_o = misroute_r;

  // W credit tracks accepted AWs whose last data beat has not yet been forwarded.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      credit_r   <= '0;
      misroute_r <= 1'b0;
    end else begin
      misroute_r <= (g_awvalid_i & aw_mis_s) | (g_wvalid_i & w_mis_s) | (g_arvalid_i & ar_mis_s);
      if (aw_acc_s && !w_last_s) begin
        credit_r <= credit_r + CREDIT_ONE;
      end else if (!aw_acc_s && w_last_s) begin
        credit_r <= credit_r - CREDIT_ONE;
      end
    end
  end

  axi_grid_sub_ni_fifo #(.WIDTH(IDW), .DEPTH(MAX_WR)) u_wr_fifo (
    .clk(clk_i), .srst(srst_i), .push(aw_acc_s), .push_data(g_awsid_i), .pop(b_acc_s),
    .head(wr_head_s), .full(wr_full_s), .empty(wr_empty_s)
  );

  axi_grid_sub_ni_fifo #(.WIDTH(IDW), .DEPTH(MAX_RD)) u_rd_fifo (
    .clk(clk_i), .srst(srst_i), .push(ar_acc_s), .push_data(g_arsid_i),
    .pop(r_acc_s & m_rchan_i.last), .head(rd_head_s), .full(rd_full_s), .empty(rd_empty_s)
  );

  axi_grid_sub_ni_skid #(.WIDTH($bits(grid_aw_chan_t))) u_aw_skid (
    .clk(clk_i), .srst(srst_i), .in_data(g_awchan_i), .in_valid(g_awvalid_i & ~aw_mis_s & ~wr_full_s),
    .in_ready(aw_skid_ready_s), .out_data(m_awchan_o), .out_valid(m_awvalid_o), .out_ready(m_awready_i)
  );

  axi_grid_sub_ni_skid #(.WIDTH($bits(grid_w_chan_t))) u_w_skid (
    .clk(clk_i), .srst(srst_i), .in_data(g_wchan_i), .in_valid(g_wvalid_i & ~w_mis_s & (credit_r != '0)),
    .in_ready(w_skid_ready_s), .out_data(m_wchan_o), .out_valid(m_wvalid_o), .out_ready(m_wready_i)
  );

  axi_grid_sub_ni_skid #(.WIDTH($bits(grid_ar_chan_t))) u_ar_skid (
    .clk(clk_i), .srst(srst_i), .in_data(g_archan_i), .in_valid(g_arvalid_i & ~ar_mis_s & ~rd_full_s),
    .in_ready(ar_skid_ready_s), .out_data(m_archan_o), .out_valid(m_arvalid_o), .out_ready(m_arready_i)
  );

  axi_grid_sub_ni_skid #(.WIDTH(BW)) u_b_skid (
    .clk(clk_i), .srst(srst_i), .in_data(b_in_s), .in_valid(m_bvalid_i & ~wr_empty_s),
    .in_ready(b_skid_ready_s), .out_data(b_out_s), .out_valid(g_bvalid_o), .out_ready(g_bready_i)
  );

  axi_grid_sub_ni_skid #(.WIDTH(RW)) u_r_skid (
    .clk(clk_i), .srst(srst_i), .in_data(r_in_s), .in_valid(m_rvalid_i & ~rd_empty_s),
    .in_ready(r_skid_ready_s), .out_data(r_out_s), .out_valid(g_rvalid_o), .out_ready(g_rready_i)
  );
endmodule

// File: tb/tb_axi_grid_sub_ni.sv
// Scoreboard bench for axi_grid_sub_ni: drivers push expected beats, per-channel monitors pop and compare.
module tb_axi_grid_sub_ni;
  import axi_default_param_pkg::*;

  localparam grid_id_t NI = 4'd0;
  localparam int BUDGET = 200;

  typedef struct packed {grid_id_t did; grid_id_t sid; grid_b_chan_t chan;} gb_t;
  typedef struct packed {grid_id_t did; grid_id_t sid; grid_r_chan_t chan;} gr_t;

  logic clk = 1'b0;
  logic srst;
  grid_id_t g_awdid_i, g_awsid_i, g_wdid_i, g_wsid_i, g_ardid_i, g_arsid_i;
  grid_id_t g_bdid_o, g_bsid_o, g_rdid_o, g_rsid_o;
  grid_aw_chan_t g_awchan_i, m_awchan_o;
  grid_w_chan_t  g_wchan_i, m_wchan_o;
  grid_ar_chan_t g_archan_i, m_archan_o;
  grid_b_chan_t  g_bchan_o, m_bchan_i;
  grid_r_chan_t  g_rchan_o, m_rchan_i;
  logic g_awvalid_i, g_awready_o, g_wvalid_i, g_wready_o, g_arvalid_i, g_arready_o;
  logic g_bvalid_o, g_bready_i, g_rvalid_o, g_rready_i;
  logic m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i, m_arvalid_o, m_arready_i;
  logic m_bvalid_i, m_bready_o, m_rvalid_i, m_rready_o, misroute_o;

  int checks = 0;
  int errors = 0;
  int mis_pulses = 0;
  int mr_hs = 0;
  grid_aw_chan_t q_maw[$];
  grid_w_chan_t  q_mw[$];
  grid_ar_chan_t q_mar[$];
  gb_t q_gb[$];
  gr_t q_gr[$];

  axi_grid_sub_ni dut (
    .clk_i(clk), .srst_i(srst),
    .g_awdid_i(g_awdid_i), .g_awsid_i(g_awsid_i), .g_awchan_i(g_awchan_i), .g_awvalid_i(g_awvalid_i), .g_awready_o(g_awready_o),
    .g_wdid_i(g_wdid_i), .g_wsid_i(g_wsid_i), .g_wchan_i(g_wchan_i), .g_wvalid_i(g_wvalid_i), .g_wready_o(g_wready_o),
    .g_ardid_i(g_ardid_i), .g_arsid_i(g_arsid_i), .g_archan_i(g_archan_i), .g_arvalid_i(g_arvalid_i), .g_arready_o(g_arready_o),
    .g_bdid_o(g_bdid_o), .g_bsid_o(g_bsid_o), .g_bchan_o(g_bchan_o), .g_bvalid_o(g_bvalid_o), .g_bready_i(g_bready_i),
    .g_rdid_o(g_rdid_o), .g_rsid_o(g_rsid_o), .g_rchan_o(g_rchan_o), .g_rvalid_o(g_rvalid_o), .g_rready_i(g_rready_i),
    .m_awchan_o(m_awchan_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wchan_o(m_wchan_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_archan_o(m_archan_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_bchan_i(m_bchan_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_rchan_i(m_rchan_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .misroute_o(misroute_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake expected handshake within %0d cycles", name, BUDGET);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected beat %0h expected none", name, act);
  endtask

  // Monitors: compare every output handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (!srst && m_awvalid_o && m_awready_i) begin
      if (q_maw.size() == 0) unexpected("m_aw", 64'(m_awchan_o));
      else check("m_aw", 64'(m_awchan_o), 64'(q_maw.pop_front()));
    end
    if (!srst && m_wvalid_o && m_wready_i) begin
      if (q_mw.size() == 0) unexpected("m_w", 64'(m_wchan_o));
      else check("m_w", 64'(m_wchan_o), 64'(q_mw.pop_front()));
    end
    if (!srst && m_arvalid_o && m_arready_i) begin
      if (q_mar.size() == 0) unexpected("m_ar", 64'(m_archan_o));
      else check("m_ar", 64'(m_archan_o), 64'(q_mar.pop_front()));
    end
    if (!srst && g_bvalid_o && g_bready_i) begin
      if (q_gb.size() == 0) unexpected("g_b", 64'({g_bdid_o, g_bsid_o, g_bchan_o}));
      else check("g_b", 64'({g_bdid_o, g_bsid_o, g_bchan_o}), 64'(q_gb.pop_front()));
    end
    if (!srst && g_rvalid_o && g_rready_i) begin
      if (q_gr.size() == 0) unexpected("g_r", 64'({g_rdid_o, g_rsid_o, g_rchan_o}));
      else check("g_r", 64'({g_rdid_o, g_rsid_o, g_rchan_o}), 64'(q_gr.pop_front()));
    end
    if (misroute_o) mis_pulses++;
    if (!srst && m_rvalid_i && m_rready_o) mr_hs++;
  end

  task automatic send_aw(input grid_id_t did, input grid_id_t sid, input grid_aw_chan_t c);
    int n = 0;
    g_awdid_i = did; g_awsid_i = sid; g_awchan_i = c; g_awvalid_i = 1'b1;
    @(negedge clk);
    while (!g_awready_o && n < BUDGET) begin @(negedge clk); n++; end
    if (!g_awready_o) timeout_fail("aw handshake");
    else if (did == NI) q_maw.push_back(c);
    @(posedge clk); #1;
    g_awvalid_i = 1'b0; g_awdid_i = NI;
  endtask

  task automatic send_w(input grid_id_t did, input grid_w_chan_t c);
    int n = 0;
    g_wdid_i = did; g_wsid_i = 4'd15; g_wchan_i = c; g_wvalid_i = 1'b1;
    @(negedge clk);
    while (!g_wready_o && n < BUDGET) begin @(negedge clk); n++; end
    if (!g_wready_o) timeout_fail("w handshake");
    else if (did == NI) q_mw.push_back(c);
    @(posedge clk); #1;
    g_wvalid_i = 1'b0; g_wdid_i = NI;
  endtask

  task automatic send_ar(input grid_id_t did, input grid_id_t sid, input grid_ar_chan_t c);
    int n = 0;
    g_ardid_i = did; g_arsid_i = sid; g_archan_i = c; g_arvalid_i = 1'b1;
    @(negedge clk);
    while (!g_arready_o && n < BUDGET) begin @(negedge clk); n++; end
    if (!g_arready_o) timeout_fail("ar handshake");
    else if (did == NI) q_mar.push_back(c);
    @(posedge clk); #1;
    g_arvalid_i = 1'b0; g_ardid_i = NI;
  endtask

  task automatic send_mb(input grid_b_chan_t c, input grid_id_t exp_did);
    int n = 0;
    m_bchan_i = c; m_bvalid_i = 1'b1;
    @(negedge clk);
    while (!m_bready_o && n < BUDGET) begin @(negedge clk); n++; end
    if (!m_bready_o) timeout_fail("m_b handshake");
    else q_gb.push_back('{did: exp_did, sid: NI, chan: c});
    @(posedge clk); #1;
    m_bvalid_i = 1'b0;
  endtask

  task automatic send_mr(input grid_r_chan_t c, input grid_id_t exp_did);
    int n = 0;
    m_rchan_i = c; m_rvalid_i = 1'b1;
    @(negedge clk);
    while (!m_rready_o && n < BUDGET) begin @(negedge clk); n++; end
    if (!m_rready_o) timeout_fail("m_r handshake");
    else q_gr.push_back('{did: exp_did, sid: NI, chan: c});
    @(posedge clk); #1;
    m_rvalid_i = 1'b0;
  endtask

  function automatic grid_r_chan_t rbeat(input logic [3:0] id, input logic [31:0] d, input logic last);
    return '{id: id, data: d, resp: 2'd0, last: last};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mis0;
    int hs0;
    srst = 1'b1;
    g_awdid_i = NI; g_awsid_i = 4'd0; g_awchan_i = '0; g_awvalid_i = 1'b0;
    g_wdid_i = NI; g_wsid_i = 4'd0; g_wchan_i = '0; g_wvalid_i = 1'b0;
    g_ardid_i = NI; g_arsid_i = 4'd0; g_archan_i = '0; g_arvalid_i = 1'b0;
    g_bready_i = 1'b1; g_rready_i = 1'b1;
    m_awready_i = 1'b1; m_wready_i = 1'b1; m_arready_i = 1'b1;
    m_bchan_i = '0; m_bvalid_i = 1'b0; m_rchan_i = '0; m_rvalid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;

    // reset state
    check("rst valids", {m_awvalid_o, m_wvalid_o, m_arvalid_o, g_bvalid_o, g_rvalid_o, misroute_o}, 6'b0);
    check("rst m_awchan", 64'(m_awchan_o), 64'd0);
    check("rst g_bdid", 64'(g_bdid_o), 64'd0);
    check("rst awready", g_awready_o, 1'b1);
    check("rst wready no credit", g_wready_o, 1'b0);
    check("rst bready fifo empty", m_bready_o, 1'b0);

    // single write
    send_aw(NI, 4'd3, '{id: 4'd1, addr: 32'h1000, len: 8'd3});
    check("m_aw latency", m_awvalid_o, 1'b1);
    for (int i = 0; i < 4; i++) send_w(NI, '{data: 32'hA0 + 32'(i), strb: 4'hF, last: (i == 3)});
    send_mb('{id: 4'd1, resp: 2'd0}, 4'd3);
    repeat (3) @(posedge clk); #1;

    // W presented before its AW
    fork
      begin
        for (int i = 0; i < 4; i++) send_w(NI, '{data: 32'hB0 + 32'(i), strb: 4'h3, last: (i == 3)});
      end
      begin
        for (int k = 0; k < 5; k++) begin @(negedge clk); check("w stalled before aw", g_wready_o, 1'b0); end
        @(posedge clk); #1;
        send_aw(NI, 4'd4, '{id: 4'd2, addr: 32'h2000, len: 8'd3});
      end
    join
    send_mb('{id: 4'd2, resp: 2'd2}, 4'd4);
    repeat (3) @(posedge clk); #1;

    // reads: fifth AR stalls until first R last beat
    send_ar(NI, 4'd1, '{id: 4'd3, addr: 32'h100, len: 8'd1});
    send_ar(NI, 4'd2, '{id: 4'd4, addr: 32'h200, len: 8'd0});
    send_ar(NI, 4'd5, '{id: 4'd5, addr: 32'h300, len: 8'd0});
    send_ar(NI, 4'd6, '{id: 4'd6, addr: 32'h400, len: 8'd0});
    g_ardid_i = NI; g_arsid_i = 4'd7; g_archan_i = '{id: 4'd7, addr: 32'h500, len: 8'd1}; g_arvalid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin @(negedge clk); check("ar5 stalled", g_arready_o, 1'b0); end
    @(posedge clk); #1;
    send_mr(rbeat(4'd3, 32'h11, 1'b0), 4'd1);
    @(negedge clk); check("ar5 still stalled mid burst", g_arready_o, 1'b0);
    @(posedge clk); #1;
    send_mr(rbeat(4'd3, 32'h12, 1'b1), 4'd1);
    send_ar(NI, 4'd7, '{id: 4'd7, addr: 32'h500, len: 8'd1});
    send_mr(rbeat(4'd4, 32'h21, 1'b1), 4'd2);
    send_mr(rbeat(4'd5, 32'h51, 1'b1), 4'd5);
    send_mr(rbeat(4'd6, 32'h61, 1'b1), 4'd6);
    send_mr(rbeat(4'd7, 32'h71, 1'b0), 4'd7);
    send_mr(rbeat(4'd7, 32'h72, 1'b1), 4'd7);
    repeat (3) @(posedge clk); #1;

    // misroute on AW, W and AR
    mis0 = mis_pulses;
    send_aw(grid_id_t'(NI + 4'd1), 4'd3, '{id: 4'd9, addr: 32'hDEAD, len: 8'd0});
    check("misroute pulse", misroute_o, 1'b1);
    @(posedge clk); #1;
    check("misroute one cycle", misroute_o, 1'b0);
    send_w(grid_id_t'(NI + 4'd1), '{data: 32'hBAD, strb: 4'hF, last: 1'b1});
    send_ar(grid_id_t'(NI + 4'd2), 4'd3, '{id: 4'd9, addr: 32'hBEEF, len: 8'd0});
    m_bchan_i = '{id: 4'd9, resp: 2'd0}; m_bvalid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin @(negedge clk); check("b held with empty fifo", m_bready_o, 1'b0); end
    @(posedge clk); #1;
    m_bvalid_i = 1'b0;
    check("misroute count", 64'(mis_pulses - mis0), 64'd3);

    // R backpressure during an 8-beat burst
    send_ar(NI, 4'd2, '{id: 4'd8, addr: 32'h800, len: 8'd7});
    g_rready_i = 1'b0;
    hs0 = mr_hs;
    fork
      begin
        for (int i = 0; i < 8; i++) send_mr(rbeat(4'd8, 32'h80 + 32'(i), (i == 7)), 4'd2);
      end
      begin
        repeat (6) @(negedge clk);
        check("r beats buffered", 64'(mr_hs - hs0), 64'd2);
        check("m_rready low when full", m_rready_o, 1'b0);
        repeat (4) @(negedge clk);
        check("g_rvalid held", g_rvalid_o, 1'b1);
        @(posedge clk); #1;
        g_rready_i = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // reset mid write burst
    m_awready_i = 1'b0; m_wready_i = 1'b0;
    send_aw(NI, 4'd5, '{id: 4'd10, addr: 32'hA00, len: 8'd3});
    send_w(NI, '{data: 32'hC0, strb: 4'hF, last: 1'b0});
    send_w(NI, '{data: 32'hC1, strb: 4'hF, last: 1'b0});
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    q_maw.delete(); q_mw.delete();
    check("post-srst valids", {m_awvalid_o, m_wvalid_o, m_arvalid_o, g_bvalid_o, g_rvalid_o, misroute_o}, 6'b0);
    check("post-srst m_wchan", 64'(m_wchan_o), 64'd0);
    m_awready_i = 1'b1; m_wready_i = 1'b1;
    g_wdid_i = NI; g_wchan_i = '{data: 32'hD0, strb: 4'hF, last: 1'b0}; g_wvalid_i = 1'b1;
    @(negedge clk); check("credit zero after srst", g_wready_o, 1'b0);
    @(posedge clk); #1;
    send_aw(NI, 4'd3, '{id: 4'd11, addr: 32'hB00, len: 8'd3});
    for (int i = 0; i < 4; i++) send_w(NI, '{data: 32'hD0 + 32'(i), strb: 4'hF, last: (i == 3)});
    send_mb('{id: 4'd11, resp: 2'd1}, 4'd3);
    repeat (10) @(posedge clk); #1;

    check("q m_aw drained", 64'(q_maw.size()), 64'd0);
    check("q m_w drained", 64'(q_mw.size()), 64'd0);
    check("q m_ar drained", 64'(q_mar.size()), 64'd0);
    check("q g_b drained", 64'(q_gb.size()), 64'd0);
    check("q g_r drained", 64'(q_gr.size()), 64'd0);
    check("total misroute pulses", 64'(mis_pulses), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_grid_sub_ni.md
Name: axi_grid_sub_ni

Overview:
- Grid-side subordinate endpoint: terminates AW/W/AR grid flits addressed to NI_ID and drives a local AXI manager port.
- Returns local B/R responses onto the grid, with destination set to the original requester's source ID and source set to NI_ID.
- Mirror of the requester-side network interface; sits between a grid router port and a local AXI subordinate (memory, peripheral).

Parameters:
- grid_id_t, axi_default_param_pkg::grid_id_t, node ID type
- grid_aw_chan_t / grid_w_chan_t / grid_b_chan_t / grid_ar_chan_t / grid_r_chan_t, axi_default_param_pkg types, AXI channel payloads; w and r payloads carry field last
- NI_ID, '0, this endpoint's grid ID
- MAX_WR, 4, outstanding write transactions; power of 2, ≥2
- MAX_RD, 4, outstanding read transactions; power of 2, ≥2

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- g_aw{did,sid,chan,valid}_i / g_awready_o  in/out  grid_id_t, grid_id_t, grid_aw_chan_t, 1 / 1  grid AW request in
- g_w{did,sid,chan,valid}_i / g_wready_o  in/out  as above, grid_w_chan_t  grid W in
- g_ar{did,sid,chan,valid}_i / g_arready_o  in/out  grid_ar_chan_t  grid AR in
- g_b{did,sid,chan,valid}_o / g_bready_i  out/in  grid_b_chan_t  grid B out
- g_r{did,sid,chan,valid}_o / g_rready_i  out/in  grid_r_chan_t  grid R out
- m_aw{chan,valid}_o / m_awready_i, m_w{chan,valid}_o / m_wready_i, m_ar{chan,valid}_o / m_arready_i  out/in  local AXI requests
- m_b{chan,valid}_i / m_bready_o, m_r{chan,valid}_i / m_rready_o  in/out  local AXI responses
- misroute_o  out  1  one-cycle pulse: a flit with did != NI_ID was dropped

Behaviour:
- Reset: all *valid_o = 0, all chan/did/sid outputs = '0, sid FIFOs empty, W credit = 0, misroute_o = 0. Reset mid-burst discards all state; no partial flits are emitted afterwards.
- Every output channel uses a 2-entry skid buffer: ready depends only on local state, full throughput, 1-cycle latency from input handshake to output valid.
- AW: accept when did == NI_ID, AW skid not full, and wr sid FIFO (depth MAX_WR) not full. On accept: push sid, forward chan unchanged, W credit +1.
- W: forward only when W credit > 0, i.e. its AW has been accepted. On forwarded beat with last = 1: credit −1. W sid is not checked.
- Simultaneous AW accept and W last in the same cycle: credit unchanged.
- AR: accept when did == NI_ID, skid not full, and rd sid FIFO (depth MAX_RD) not full; push sid, forward chan.
- Misrouted flit (did != NI_ID) on AW, W or AR: accepted immediately, discarded, misroute_o = 1 next cycle. Such an AW pushes nothing and grants no credit.
- B: accept m_b when wr FIFO non-empty and B skid not full. Emit chan unchanged, did = FIFO head, sid = NI_ID; pop on accept.
- R: same as B but uses the rd FIFO; pop only on the beat with last = 1.
- m_b/m_r beats arriving with the matching FIFO empty: m_bready_o / m_rready_o held 0 (protocol error; held, not dropped).
- The local subordinate returns responses in request order per direction; no ID reordering is supported.
- Full FIFO: the corresponding g_*ready_o = 0, with no combinational path from valid.

Test Plan:
- Single write: AW(did=NI_ID, sid=3) then W×4, last on beat 4; local B → m_aw one cycle after accept; 4 m_w beats; g_b did=3, sid=NI_ID, chan equal to m_b.
- W before AW: W beats presented 5 cycles early → g_wready_o = 0 until AW accepted; beats then forwarded in order.
- Reads from sids 1, 2, 5, 6, 7 with MAX_RD = 4 → fifth AR stalled until first R last beat; R bursts carry did = 1, 2, 5, 6 in order.
- Misroute: AW did = NI_ID+1 → accepted, no m_aw, misroute_o pulses once, no B ever produced.
- Backpressure: g_rready_i = 0 for 10 cycles during an 8-beat R → at most 2 beats buffered, m_rready_o deasserts, no beat lost or duplicated.
- srst_i asserted mid write burst (2 of 4 W beats sent) → all valids 0 next cycle; a fresh write afterwards completes normally with credit starting at 0.
